// File: rtl/objects_mux_layered_if.sv
// Pixel/control bundle between the drawing units, the layer compositor and the VGA stage.
// Latency: none (wires only).
// Backpressure: none; one pixel per clock in both directions.
interface objects_mux_layered_if #(
  parameter int NUM_LAYERS = 8
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0]   layerDrawingRequest;
  logic [8*NUM_LAYERS-1:0] layerRGB;
  logic [NUM_LAYERS-1:0]   layerEnable;
  logic [NUM_LAYERS-1:0]   layerKeyEn;
  logic [NUM_LAYERS-1:0]   layerBlink;
  logic [7:0]              backGroundRGB;
  logic                    startOfFrame;
  logic                    fadeOutReq;
  logic                    fadeInReq;
  logic [7:0]              redOut;
  logic [7:0]              greenOut;
  logic [7:0]              blueOut;
  logic [LW-1:0]           winLayer;
  logic                    winValid;
  logic                    fadeBusy;
  logic                    fadeDone;
  logic                    blinkPhase;

  // Drawing side: supplies layers and frame/fade commands, receives the composed pixel.
  modport master (
    output layerDrawingRequest, layerRGB, layerEnable, layerKeyEn, layerBlink,
           backGroundRGB, startOfFrame, fadeOutReq, fadeInReq,
    input  redOut, greenOut, blueOut, winLayer, winValid, fadeBusy, fadeDone, blinkPhase
  );

  // Compositor side.
  modport slave (
    input  layerDrawingRequest, layerRGB, layerEnable, layerKeyEn, layerBlink,
           backGroundRGB, startOfFrame, fadeOutReq, fadeInReq,
    output redOut, greenOut, blueOut, winLayer, winValid, fadeBusy, fadeDone, blinkPhase
  );
endinterface

// File: rtl/objects_mux_layered.sv
// Fixed-priority RGB332 layer compositor with mask, colour key, blink and frame-synchronous fade.
// Latency: 2 clocks from layer inputs to colour/winLayer/winValid outputs.
// Backpressure: none; a new pixel is accepted every clock.
module objects_mux_layered #(
  parameter int         NUM_LAYERS        = 8,
  parameter logic [7:0] TRANSPARENT_COLOR = 8'hFF,
  parameter int         FADE_SHIFT        = 3,
  parameter int         FRAMES_PER_STEP   = 2,
  parameter int         BLINK_FRAMES      = 16
) (
  input logic                clk,
  input logic                resetN,
  objects_mux_layered_if.slave bus
);
  localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int LVW = FADE_SHIFT + 1;
  localparam int PW  = 8 + FADE_SHIFT + 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [LVW-1:0] LMAX    = LVW'(2**FADE_SHIFT);
  localparam logic [LVW-1:0] LMAX_M1 = LVW'(2**FADE_SHIFT - 1);
  localparam logic [BCW-1:0] BMAX    = BCW'(BLINK_FRAMES - 1);
  localparam logic [FCW-1:0] FMAX    = FCW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {S_VISIBLE, S_FADING_OUT, S_BLACK, S_FADING_IN} fade_state_t;

  fade_state_t      r_state, w_state_nx;
  logic [LVW-1:0]   r_level, w_level_nx;
  logic [FCW-1:0]   r_fcnt, w_fcnt_nx;
  logic             r_done, w_done_nx;
  logic [BCW-1:0]   r_bcnt;
  logic             r_blink_phase;

  logic [NUM_LAYERS-1:0] w_elig;
  logic [7:0]            w_sel_rgb;
  logic [LW-1:0]         w_sel_idx;
  logic                  w_sel_vld;
  logic [7:0]            r_s1_rgb;
  logic [LW-1:0]         r_s1_idx;
  logic                  r_s1_vld;

  logic [7:0]    w_er, w_eg, w_eb;
  logic [7:0]    r_red, r_green, r_blue;
  logic [LW-1:0] r_s2_idx;
  logic          r_s2_vld;

  logic w_tick;
  logic w_in_req;

  // A layer competes only if it draws, is enabled, is not colour-keyed out and is not blinked off.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_elig[i] = bus.layerDrawingRequest[i] & bus.layerEnable[i]
                & ~(bus.layerKeyEn[i] & (bus.layerRGB[8*i +: 8] == TRANSPARENT_COLOR))
                & ~(bus.layerBlink[i] & r_blink_phase);
    end
  end

  // Lowest eligible index wins; walking downward lets the lowest index overwrite last.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_sel_rgb = bus.backGroundRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = LW'(i);
        w_sel_rgb = bus.layerRGB[8*i +: 8];
      end
    end
  end

  // Stage 1: register the selected colour and its origin.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_rgb <= '0;
      r_s1_idx <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_rgb <= w_sel_rgb;
      r_s1_idx <= w_sel_idx;
      r_s1_vld <= w_sel_vld;
    end
  end

  // RGB332 to 8-bit channels by replicating the channel LSB into the low bits.
  assign w_er = {r_s1_rgb[7:5], {5{r_s1_rgb[5]}}};
  assign w_eg = {r_s1_rgb[4:2], {5{r_s1_rgb[2]}}};
  assign w_eb = {r_s1_rgb[1:0], {6{r_s1_rgb[0]}}};

  // Stage 2: scale by the registered fade level; full level reproduces the channel exactly.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_s2_idx <= '0;
      r_s2_vld <= 1'b0;
    end else begin
      r_red    <= 8'((PW'(w_er) * PW'(r_level)) >> FADE_SHIFT);
      r_green  <= 8'((PW'(w_eg) * PW'(r_level)) >> FADE_SHIFT);
      r_blue   <= 8'((PW'(w_eb) * PW'(r_level)) >> FADE_SHIFT);
      r_s2_idx <= r_s1_idx;
      r_s2_vld <= r_s1_vld;
    end
  end

  // Blink half-period counter; the phase flips on the wrapping frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.startOfFrame) begin
      if (r_bcnt == BMAX) begin
        r_bcnt        <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_bcnt <= r_bcnt + BCW'(1);
      end
    end
  end

  assign w_tick   = bus.startOfFrame & (r_fcnt == FMAX);
  assign w_in_req = bus.fadeInReq & ~bus.fadeOutReq;

  // Fade state, level, step counter and completion pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_VISIBLE;
      r_level <= LMAX;
      r_fcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_level <= w_level_nx;
      r_fcnt  <= w_fcnt_nx;
      r_done  <= w_done_nx;
    end
  end

  // Requests are judged before the step tick; a state change clears the step counter,
  // so no level step is taken on the cycle a request is honoured.
  always_comb begin
    w_state_nx = r_state;
    w_level_nx = r_level;
    w_done_nx  = 1'b0;
    w_fcnt_nx  = r_fcnt;
    if (bus.startOfFrame) w_fcnt_nx = w_tick ? '0 : r_fcnt + FCW'(1);
    case (r_state)
      S_VISIBLE: begin
        if (bus.fadeOutReq) begin
          w_state_nx = S_FADING_OUT;
          w_fcnt_nx  = '0;
        end
      end
      S_FADING_OUT: begin
        if (w_in_req) begin
          w_state_nx = S_FADING_IN;
          w_fcnt_nx  = '0;
        end else if (w_tick) begin
          w_level_nx = r_level - LVW'(1);
          if (r_level == LVW'(1)) begin
            w_state_nx = S_BLACK;
            w_done_nx  = 1'b1;
            w_fcnt_nx  = '0;
          end
        end
      end
      S_BLACK: begin
        if (w_in_req) begin
          w_state_nx = S_FADING_IN;
          w_fcnt_nx  = '0;
        end
      end
      S_FADING_IN: begin
        if (bus.fadeOutReq) begin
          w_state_nx = S_FADING_OUT;
          w_fcnt_nx  = '0;
        end else if (w_tick) begin
          w_level_nx = r_level + LVW'(1);
          if (r_level == LMAX_M1) begin
            w_state_nx = S_VISIBLE;
            w_done_nx  = 1'b1;
            w_fcnt_nx  = '0;
          end
        end
      end
      default: w_state_nx = S_VISIBLE;
    endcase
  end

  assign bus.redOut     = r_red;
  assign bus.greenOut   = r_green;
  assign bus.blueOut    = r_blue;
  assign bus.winLayer   = r_s2_idx;
  assign bus.winValid   = r_s2_vld;
  assign bus.fadeBusy   = (r_state == S_FADING_OUT) || (r_state == S_FADING_IN);
  assign bus.fadeDone   = r_done;
  assign bus.blinkPhase = r_blink_phase;
endmodule

// File: tb/tb_objects_mux_layered.sv
// Bench for the layer compositor: scoreboard of expected pixels checked two clocks after issue.
// Latency: expected pixels are tagged with the cycle they must appear on.
// Backpressure: none; the monitor samples every falling edge.
module tb_objects_mux_layered;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  objects_mux_layered_if #(.NUM_LAYERS(8)) bus();

  objects_mux_layered #(
    .NUM_LAYERS(8), .TRANSPARENT_COLOR(8'hFF), .FADE_SHIFT(3),
    .FRAMES_PER_STEP(2), .BLINK_FRAMES(16)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] lay;
    logic       vld;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expected pixel whose due cycle has arrived and compare it.
  always @(negedge clk) begin
    if (resetN) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) check({e.name, " timing"}, cyc, e.cyc);
        check(e.name,
              {4'h0, bus.redOut, bus.greenOut, bus.blueOut, bus.winLayer, bus.winValid},
              {4'h0, e.r, e.g, e.b, e.lay, e.vld});
      end
      if (bus.fadeDone) done_cnt++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs are already applied; the pixel is due two edges from now.
  task automatic expect_px(string name, logic [7:0] r, logic [7:0] g, logic [7:0] b,
                           logic [2:0] lay, logic vld);
    exp_t x;
    x.cyc = cyc + 2; x.r = r; x.g = g; x.b = b; x.lay = lay; x.vld = vld; x.name = name;
    q.push_back(x);
    tick(3);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      tick(1);
      bus.startOfFrame = 1'b0;
      tick(1);
    end
  endtask

  task automatic fade_cmd(logic out_r, logic in_r);
    bus.fadeOutReq = out_r;
    bus.fadeInReq  = in_r;
    tick(1);
    bus.fadeOutReq = 1'b0;
    bus.fadeInReq  = 1'b0;
    tick(1);
  endtask

  task automatic set_rgb(int i, logic [7:0] v);
    bus.layerRGB[8*i +: 8] = v;
  endtask

  initial begin
    int d0;
    bus.layerDrawingRequest = '0;
    bus.layerRGB            = '0;
    bus.layerEnable         = '1;
    bus.layerKeyEn          = '0;
    bus.layerBlink          = '0;
    bus.backGroundRGB       = 8'h03;
    bus.startOfFrame        = 1'b0;
    bus.fadeOutReq          = 1'b0;
    bus.fadeInReq           = 1'b0;

    #2 resetN = 1'b0;
    #1;
    check("reset rgb", {bus.redOut, bus.greenOut, bus.blueOut}, 24'h0);
    check("reset win", {bus.winLayer, bus.winValid}, 4'h0);
    check("reset fade", {bus.fadeBusy, bus.fadeDone, bus.blinkPhase}, 3'b000);
    tick(2);
    resetN = 1'b1;
    tick(1);

    // Priority between layers 2 and 5.
    bus.layerDrawingRequest = 8'b0010_0100;
    set_rgb(2, 8'h1C); set_rgb(5, 8'hE0);
    expect_px("priority 2 over 5", 8'h00, 8'hFF, 8'h00, 3'd2, 1'b1);
    bus.layerDrawingRequest = 8'b0010_0000;
    expect_px("layer 5 alone", 8'hFF, 8'h00, 8'h00, 3'd5, 1'b1);
    bus.layerDrawingRequest = 8'b1000_0001;
    set_rgb(0, 8'h49); set_rgb(7, 8'hB6);
    expect_px("priority 0 over 7", 8'h40, 8'h40, 8'h7F, 3'd0, 1'b1);
    bus.layerDrawingRequest = 8'b1000_0000;
    expect_px("layer 7 expansion", 8'hBF, 8'hBF, 8'h80, 3'd7, 1'b1);

    // Mask and colour key.
    bus.layerDrawingRequest = 8'b0010_0100;
    bus.layerEnable = 8'b1111_1011;
    set_rgb(5, 8'hFF);
    bus.layerKeyEn = 8'b0010_0000;
    expect_px("mask+key background", 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);
    bus.layerKeyEn = 8'b0000_0000;
    expect_px("key disabled", 8'hFF, 8'hFF, 8'hFF, 3'd5, 1'b1);
    bus.layerEnable = '1;
    bus.layerKeyEn = 8'b0000_0100;
    set_rgb(2, 8'hFF);
    expect_px("key layer 2 falls to 5", 8'hFF, 8'hFF, 8'hFF, 3'd5, 1'b1);
    bus.layerKeyEn = '0;

    // Blink.
    bus.layerDrawingRequest = 8'b0000_0001;
    set_rgb(0, 8'h1C);
    bus.layerBlink = 8'b0000_0001;
    expect_px("blink phase0 visible", 8'h00, 8'hFF, 8'h00, 3'd0, 1'b1);
    frames(15);
    check("blink phase after 15", bus.blinkPhase, 1'b0);
    frames(1);
    check("blink phase after 16", bus.blinkPhase, 1'b1);
    expect_px("blink hidden", 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);
    frames(16);
    check("blink phase after 32", bus.blinkPhase, 1'b0);
    expect_px("blink visible again", 8'h00, 8'hFF, 8'h00, 3'd0, 1'b1);
    bus.layerBlink = '0;

    // Fade out.
    set_rgb(0, 8'hE0);
    expect_px("pre-fade red", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1);
    d0 = done_cnt;
    fade_cmd(1'b1, 1'b0);
    check("busy fading out", bus.fadeBusy, 1'b1);
    frames(1);
    expect_px("fade L8 after 1 frame", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1);
    frames(1);
    expect_px("fade L7", 8'hDF, 8'h00, 8'h00, 3'd0, 1'b1);
    frames(14);
    expect_px("fade L0", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    check("fade out done pulses", done_cnt - d0, 1);
    check("black not busy", bus.fadeBusy, 1'b0);
    fade_cmd(1'b1, 1'b0);
    check("out ignored in black", bus.fadeBusy, 1'b0);

    // Fade back in, then reversal mid-fade.
    fade_cmd(1'b0, 1'b1);
    frames(16);
    expect_px("fade in L8", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1);
    check("fade in done pulses", done_cnt - d0, 2);
    check("visible not busy", bus.fadeBusy, 1'b0);
    fade_cmd(1'b1, 1'b0);
    frames(8);
    expect_px("fade L4", 8'h7F, 8'h00, 8'h00, 3'd0, 1'b1);
    d0 = done_cnt;
    fade_cmd(1'b0, 1'b1);
    frames(2);
    expect_px("reversed L5", 8'h9F, 8'h00, 8'h00, 3'd0, 1'b1);
    check("reversal no done", done_cnt - d0, 0);
    check("reversal busy", bus.fadeBusy, 1'b1);
    fade_cmd(1'b1, 1'b1);
    frames(2);
    expect_px("simultaneous -> out L4", 8'h7F, 8'h00, 8'h00, 3'd0, 1'b1);
    frames(2);
    expect_px("fade L3", 8'h5F, 8'h00, 8'h00, 3'd0, 1'b1);
    check("busy before reset", bus.fadeBusy, 1'b1);

    // Asynchronous reset mid-fade.
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("async reset rgb", {bus.redOut, bus.greenOut, bus.blueOut}, 24'h0);
    check("async reset win", {bus.winLayer, bus.winValid}, 4'h0);
    check("async reset busy", bus.fadeBusy, 1'b0);
    tick(2);
    resetN = 1'b1;
    tick(1);
    expect_px("post-reset full level", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1);
    check("post-reset not busy", bus.fadeBusy, 1'b0);

    tick(4);
    check("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
